crossbar_req_dispatch: RTL

// Request-side scheduler for the crossbar reorder buffer.
// - Takes one upstream request stream and routes each request to one of S_QTY slaves by address decode.
// - For every read, consumes one tag from the ROB tag stream and forwards it to the slave as tuser.
// - Bounds outstanding reads per slave with credit counters, so slave responses always find a reserved ROB slot.

---
 rtl/crossbar_pkg.sv | 21 ++
 rtl/crossbar_credit_cnt.sv | 30 +++
 rtl/crossbar_req_dispatch.sv | 103 ++++++++++
 3 files changed

// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the crossbar request-side blocks.
package crossbar_pkg;

    localparam int unsigned TAG_NONE   = 0;
    localparam int unsigned REQ_ADDR_W = 32;
    localparam int unsigned REQ_DATA_W = 32;
    localparam int unsigned REQ_TAG_W  = 4;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic                  we;
        logic [REQ_DATA_W-1:0] wdata;
        logic [REQ_TAG_W-1:0]  tag;
    } req_t;

    // Slave-select width; a single-slave crossbar still gets a one-bit select.
    function automatic int unsigned sel_width(input int unsigned s_qty);
        return (s_qty < 2) ? 1 : $clog2(s_qty);
    endfunction

endpackage

// File: rtl/crossbar_credit_cnt.sv
// Per-slave outstanding-read counter: reserves on accept, releases on response.
module crossbar_credit_cnt #(
    parameter  int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign full = (cnt >= CNT_W'(MAX_OUTSTANDING));

    // A response with nothing outstanding means a slave or ROB protocol error.
    underflow_a: assert property (@(posedge clk) disable iff (!resetn)
        (dec && !inc) |-> (cnt != '0));

endmodule

// File: rtl/crossbar_req_dispatch.sv
// Routes upstream requests to slaves by address, attaching ROB tags to reads
// and bounding in-flight reads per slave with credit counters.
module crossbar_req_dispatch
    import crossbar_pkg::*;
#(
    parameter int unsigned S_QTY           = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned TDATA_WIDTH     = 32,
    parameter int unsigned TUSER_WIDTH     = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   s_axis_req_tvalid,
    output logic                   s_axis_req_tready,
    input  logic [ADDR_WIDTH-1:0]  s_axis_req_taddr,
    input  logic                   s_axis_req_twe,
    input  logic [TDATA_WIDTH-1:0] s_axis_req_twdata,
    input  logic                   s_axis_tag_tvalid,
    output logic                   s_axis_tag_tready,
    input  logic [TUSER_WIDTH-1:0] s_axis_tag_tdata,
    output logic [S_QTY-1:0]       m_axis_req_tvalid,
    input  logic [S_QTY-1:0]       m_axis_req_tready,
    output logic [ADDR_WIDTH-1:0]  m_axis_req_taddr,
    output logic                   m_axis_req_twe,
    output logic [TDATA_WIDTH-1:0] m_axis_req_twdata,
    output logic [TUSER_WIDTH-1:0] m_axis_req_tuser,
    input  logic [S_QTY-1:0]       rsp_tvalid,
    output logic                   idle
);

    localparam int unsigned SEL_W = sel_width(S_QTY);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [SEL_W-1:0] sel_raw;
    logic [SEL_W-1:0] sel_c;
    logic             free_c;
    logic             rd_ok_c;
    logic             accept_c;
    logic [S_QTY-1:0] credit_inc;
    logic [S_QTY-1:0] credit_full;
    logic [S_QTY-1:0] credit_busy;
    logic [CNT_W-1:0] credit_cnt [S_QTY];

    logic             held;
    logic [SEL_W-1:0] held_sel;

    // Address decode; out-of-range selects fold onto the last slave.
    assign sel_raw = s_axis_req_taddr[ADDR_WIDTH-1 -: SEL_W];
    assign sel_c   = (32'(sel_raw) >= S_QTY) ? SEL_W'(S_QTY - 1) : sel_raw;

    assign free_c   = ~held | m_axis_req_tready[held_sel];
    assign rd_ok_c  = s_axis_tag_tvalid & ~credit_full[sel_c];

    assign s_axis_req_tready = resetn & free_c & (s_axis_req_twe | rd_ok_c);
    assign accept_c          = s_axis_req_tvalid & s_axis_req_tready;
    assign s_axis_tag_tready = accept_c & ~s_axis_req_twe;

    for (genvar i = 0; i < int'(S_QTY); i++) begin : g_credit
        assign credit_inc[i]  = s_axis_tag_tready & (sel_c == SEL_W'(i));
        assign credit_busy[i] = |credit_cnt[i];

        crossbar_credit_cnt #(
            .MAX_OUTSTANDING(MAX_OUTSTANDING)
        ) u_cnt (
            .clk   (clk),
            .resetn(resetn),
            .inc   (credit_inc[i]),
            .dec   (rsp_tvalid[i]),
            .cnt   (credit_cnt[i]),
            .full  (credit_full[i])
        );
    end

    // Output stage occupancy; payload only moves on accept so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            held <= 1'b0;
        end else if (free_c) begin
            held <= accept_c;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_c) begin
            held_sel          <= sel_c;
            m_axis_req_taddr  <= s_axis_req_taddr;
            m_axis_req_twe    <= s_axis_req_twe;
            m_axis_req_twdata <= s_axis_req_twdata;
            m_axis_req_tuser  <= s_axis_req_twe ? TUSER_WIDTH'(TAG_NONE) : s_axis_tag_tdata;
        end
    end

    always_comb begin
        m_axis_req_tvalid = '0;
        if (held) begin
            m_axis_req_tvalid[held_sel] = 1'b1;
        end
    end

    assign idle = ~held & ~|credit_busy;

endmodule
